core_sequencer: RTL

//  Multi-cycle control FSM for the RV32 integer core. It sequences PC, instruction memory, register file and ALU

---
 rtl/core_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32 core, with imem timeout and illegal-opcode trap.
// Optional retired-instruction counter enabled by defining SEQ_INSTRET_EN; otherwise instret reads 0.
module core_sequencer #(
  parameter int unsigned IMEM_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             alu_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [7:0] WAIT_LAST  = 8'(IMEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Wait counter only counts inside FETCH; any exit from FETCH leaves it at 0.
  always_comb begin
    state_d = state_q;
    wait_d  = 8'd0;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack)                state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d = S_FAULT;
        else                          wait_d  = wait_q + 8'd1;
      end
      S_DECODE:    state_d = (opcode == OPC_OP || opcode == OPC_OP_IMM) ? S_EXECUTE : S_FAULT;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = halt_req ? S_HALTED : S_FETCH;
      S_HALTED:    if (start) state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  assign imem_req = (state_q == S_FETCH);
  assign ir_load  = (state_q == S_FETCH) && imem_ack;
  assign alu_en   = (state_q == S_EXECUTE);
  assign rf_we    = (state_q == S_WRITEBACK);
  assign pc_en    = (state_q == S_WRITEBACK);
  assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign fault    = (state_q == S_FAULT);
  assign state    = state_q;

`ifdef SEQ_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_q == S_WRITEBACK) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
